// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with programmable modulus, enable, clamped parallel load
// and wrap-or-saturate limit behaviour; tc pulses for every enabled step that hits a limit.
module updown_counter_n #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0,
    parameter int INIT     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH:0] LIMIT  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] INIT_V = (WIDTH+1)'(INIT);

    generate
        if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
            INIT < 0 || INIT >= MODULUS) begin : g_bad_params
            $error("updown_counter_n: illegal WIDTH/MODULUS/INIT combination");
        end
    endgenerate

    // State is kept one bit wider than the output so the limit compares never
    // depend on natural 2^WIDTH rollover; the top bit always stays zero.
    logic [WIDTH:0] cnt_q = INIT_V;
    logic           tc_q  = 1'b0;

    logic [WIDTH:0] load_ext;
    logic [WIDTH:0] load_next;
    logic [WIDTH:0] step_next;
    logic           step_tc;

    always_comb begin
        load_ext  = {1'b0, load_val};
        load_next = (load_ext > LIMIT) ? LIMIT : load_ext;
        step_next = cnt_q;
        step_tc   = 1'b0;
        if (!up_dn) begin
            if (cnt_q == LIMIT) begin
                step_tc   = 1'b1;
                step_next = SATURATE ? LIMIT : '0;
            end else begin
                step_next = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == '0) begin
                step_tc   = 1'b1;
                step_next = SATURATE ? '0 : LIMIT;
            end else begin
                step_next = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= INIT_V;
            tc_q  <= 1'b0;
        end else if (load) begin
            cnt_q <= load_next;
            tc_q  <= 1'b0;
        end else if (en) begin
            cnt_q <= step_next;
            tc_q  <= step_tc;
        end else begin
            tc_q  <= 1'b0;
        end
    end

    assign cnt_out = cnt_q[WIDTH-1:0];
    assign tc      = tc_q;
    assign at_max  = (cnt_q == LIMIT);
    assign at_min  = (cnt_q == '0);

endmodule

// File: doc/updown_counter_n.md
# updown_counter_n

Parametrised synchronous up/down counter with programmable modulus, count enable, parallel load and selectable wrap or saturate behaviour at the limits. It is the generalised successor of the lab's fixed 2-bit up/down counter and serves as the common counting element for later lab blocks (timers, position counters, display scanners). Count state is fully registered. The block flags every limit event with a one-cycle registered terminal-count pulse.

## Interface
- WIDTH, 4, counter width in bits (1..16)
- MODULUS, 16, count range 0..MODULUS-1; legal 2..2^WIDTH
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits
- INIT, 0, value loaded by reset; must be < MODULUS

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; clock clk
- en  in  1  count enable; one step per enabled cycle
- up_dn  in  1  direction: 0 = increment, 1 = decrement (same polarity as the 2-bit counter)
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value to load
- cnt_out  out  WIDTH  current count (registered)
- tc  out  1  terminal-count pulse (registered)
- at_max  out  1  cnt_out == MODULUS-1 (combinational from register)
- at_min  out  1  cnt_out == 0 (combinational from register)

## Operation
- Priority per edge: reset low > load > en > hold.
- reset low: cnt_out <= INIT, tc <= 0.
- load (reset high): cnt_out <= load_val if load_val < MODULUS, else MODULUS-1 (clamp); tc <= 0; en ignored that cycle.
- en=1, up_dn=0: cnt_out < MODULUS-1 -> cnt_out+1, tc <= 0. cnt_out == MODULUS-1 -> wrap mode: 0, tc <= 1; saturate mode: stays MODULUS-1, tc <= 1.
- en=1, up_dn=1: cnt_out > 0 -> cnt_out-1, tc <= 0. cnt_out == 0 -> wrap mode: MODULUS-1, tc <= 1; saturate mode: stays 0, tc <= 1.
- en=0, load=0: cnt_out holds, tc <= 0.
- tc therefore means "an enabled step hit a limit on this edge". In saturate mode, tc stays high for every consecutive cycle that en pushes against the limit.
- Arithmetic is done in WIDTH+1 bits internally. Never rely on natural 2^WIDTH rollover; the modulus compare is explicit, so non-power-of-two MODULUS works.
- up_dn may change every cycle. Each edge uses the value sampled at that edge. There is no direction-change penalty.
- Illegal parameter combos (MODULUS > 2^WIDTH, INIT >= MODULUS) are flagged by a simulation-time check. They are not synthesised.

## Timing
- Latency 1 cycle: inputs sampled on edge N are visible on cnt_out/tc after edge N.
- tc is high for exactly one cycle per limit event in wrap mode. It aligns with the cycle in which cnt_out shows the wrapped value.
- at_max/at_min follow cnt_out with no extra register stage. They are valid in the same cycle as cnt_out.
- Reset mid-count: the next edge with reset low forces INIT and clears tc, regardless of en/load.
- Power-up value before the first reset is INIT (register initialiser).
- Throughput: one step per cycle, no stall or busy state.

## Test plan
- WIDTH=4, MODULUS=10, wrap; reset, then en=1, up_dn=0 for 12 cycles -> cnt_out 1..9,0,1,2; tc high only in the cycle cnt_out==0; at_max high when cnt_out==9.
- Same config, up_dn=1 from cnt_out=1 for 3 cycles -> 0, 9, 8; tc high only in the cycle showing 9.
- SATURATE=1, MODULUS=10: count up from 7 with en held 5 cycles -> 8, 9, 9, 9, 9; tc low, high, high, high in the last four cycles? No: tc is 0 on the step to 8 and on the step to 9, then 1 on each of the three held cycles.
- load=1, load_val=4 with en=1 -> cnt_out=4, tc=0. Then load_val=13 (MODULUS=10) -> cnt_out clamps to 9.
- Mid-count reset: at cnt_out=6, reset=0 together with load=1 and en=1 -> next cycle cnt_out=INIT (0), tc=0. Counting resumes the cycle after reset is released.
- Toggle up_dn every cycle with en=1 starting at 5 -> 6, 5, 6, 5. Hold en=0 for 3 cycles -> cnt_out constant, tc=0.
